// File: rtl/rr_arbiter_hold.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_hold
// Brief    : Registered round-robin arbiter with grant hold, bounded by
//            MAX_HOLD cycles while others wait. Optional binary grant index
//            output enabled by defining RR_ARB_GRANT_INDEX_EN.
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter_hold #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] grant,
    output logic             grant_valid
`ifdef RR_ARB_GRANT_INDEX_EN
    ,
    output logic [$clog2(WIDTH)-1:0] grant_idx
`endif
);

    localparam int c_CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = (MAX_HOLD == 0) ? '0 : c_CNT_W'(MAX_HOLD - 1);
    localparam logic c_LIMITED = (MAX_HOLD != 0);

    logic [WIDTH-1:0]   r_grant;
    logic [WIDTH-1:0]   r_ptr;
    logic               r_valid;
    logic [c_CNT_W-1:0] r_hold_cnt;

    logic               w_owner_req;
    logic               w_others;
    logic               w_expire;
    logic               w_hold;
    logic [WIDTH-1:0]   w_cand;
    logic [WIDTH-1:0]   w_masked;
    logic [WIDTH-1:0]   w_pick;
    logic [WIDTH-1:0]   w_winner;
    logic [WIDTH-1:0]   w_next_grant;

    assign w_owner_req = |(req & r_grant);
    assign w_others    = |(req & ~r_grant);
    // The counter saturates at its last value, so a long sole owner yields
    // one cycle after a competitor shows up.
    assign w_expire    = c_LIMITED && (r_hold_cnt == c_CNT_LAST) && w_others;
    assign w_hold      = w_owner_req && !w_expire;

    assign w_cand       = w_expire ? (req & ~r_grant) : req;
    assign w_masked     = w_cand & ~(r_ptr - WIDTH'(1));
    assign w_pick       = (|w_masked) ? w_masked : w_cand;
    assign w_winner     = w_pick & (~w_pick + WIDTH'(1));
    assign w_next_grant = w_hold ? r_grant : w_winner;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant    <= '0;
            r_valid    <= 1'b0;
            r_ptr      <= WIDTH'(1);
            r_hold_cnt <= '0;
        end else begin
            r_grant <= w_next_grant;
            r_valid <= |w_next_grant;
            if (w_hold) begin
                if (r_hold_cnt != c_CNT_LAST) begin
                    r_hold_cnt <= r_hold_cnt + c_CNT_W'(1);
                end
            end else begin
                r_hold_cnt <= '0;
                if (|w_winner) begin
                    r_ptr <= {w_winner[WIDTH-2:0], w_winner[WIDTH-1]};
                end
            end
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_valid;

`ifdef RR_ARB_GRANT_INDEX_EN
    localparam int c_IDX_W = $clog2(WIDTH);

    logic [c_IDX_W-1:0] w_win_idx;
    logic [c_IDX_W-1:0] r_idx;

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_winner[i]) begin
                w_win_idx = c_IDX_W'(i);
            end
        end
    end

    // Index tracks the last real grant and is left alone while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
        end else if (!w_hold && (|w_winner)) begin
            r_idx <= w_win_idx;
        end
    end

    assign grant_idx = r_idx;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_hold.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter_hold
// Brief    : Scoreboard bench for rr_arbiter_hold (WIDTH=8, MAX_HOLD=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_rr_arbiter_hold;

    localparam int W     = 8;
    localparam int MH    = 4;
    localparam int BOUND = (W - 1) * MH + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] req;
    logic [W-1:0] grant;
    logic         grant_valid;
`ifdef RR_ARB_GRANT_INDEX_EN
    logic [2:0]   grant_idx;
`endif

    always #5 clk = ~clk;

    rr_arbiter_hold #(
        .WIDTH    (W),
        .MAX_HOLD (MH)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid)
`ifdef RR_ARB_GRANT_INDEX_EN
        ,
        .grant_idx   (grant_idx)
`endif
    );

    typedef struct packed {
        logic [W-1:0] g;
        logic         v;
        logic [2:0]   idx;
    } exp_t;

    exp_t         sb_q[$];
    int           n_cmp = 0;
    int           n_err = 0;

    logic [W-1:0] m_grant;
    int           m_ptr;
    int           m_cnt;
    int           m_idx;
    int           wait_c[W];
    int           max_wait = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference: circular search from the priority index.
    task automatic model_step(input logic [W-1:0] r, input bit rv);
        logic [W-1:0] cand;
        bit           expire;
        if (rv) begin
            m_grant = '0;
            m_ptr   = 0;
            m_cnt   = 0;
            m_idx   = 0;
        end else begin
            expire = (m_cnt == MH - 1) && ((r & ~m_grant) != 0);
            if (((r & m_grant) != 0) && !expire) begin
                if (m_cnt < MH - 1) m_cnt++;
            end else begin
                cand    = expire ? (r & ~m_grant) : r;
                m_grant = '0;
                m_cnt   = 0;
                for (int k = 0; k < W; k++) begin
                    int j;
                    j = (m_ptr + k) % W;
                    if (cand[j]) begin
                        m_grant = W'(1) << j;
                        m_ptr   = (j + 1) % W;
                        m_idx   = j;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic [W-1:0] r, input bit rv = 1'b0);
        exp_t e;
        req = r;
        rst = rv;
        model_step(r, rv);
        e.g   = m_grant;
        e.v   = |m_grant;
        e.idx = 3'(m_idx);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq("grant", 32'(grant), 32'(e.g));
        check_eq("grant_valid", 32'(grant_valid), 32'(e.v));
`ifdef RR_ARB_GRANT_INDEX_EN
        check_eq("grant_idx", 32'(grant_idx), 32'(e.idx));
`endif
        check_eq("onehot0", 32'($onehot0(grant)), 32'd1);
        check_eq("grant_wo_req", 32'(grant & ~r), 32'd0);
        for (int i = 0; i < W; i++) begin
            if (!rv && r[i] && !grant[i]) wait_c[i]++;
            else wait_c[i] = 0;
            if (wait_c[i] > max_wait) max_wait = wait_c[i];
        end
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        m_grant = '0; m_ptr = 0; m_cnt = 0; m_idx = 0;
        for (int i = 0; i < W; i++) wait_c[i] = 0;

        step(8'h00, 1'b1);
        step(8'h00, 1'b1);
        // Hold of requester 0, then hand-off without an idle cycle
        repeat (4) step(8'b0000_0101);
        step(8'b0000_0100);
        // Full contention: each owner keeps grant for MAX_HOLD cycles
        step(8'h00, 1'b1);
        repeat (36) step(8'hFF);
        // Sole requester holds indefinitely, priority wraps after it
        repeat (20) step(8'h80);
        step(8'h00);
        repeat (2) step(8'h81);
        // Saturated owner yields once a competitor appears
        repeat (6) step(8'h80);
        repeat (3) step(8'hC0);
        // Reset in the middle of a grant
        step(8'h00, 1'b1);
        repeat (2) step(8'h10);
        step(8'h10, 1'b1);
        step(8'h11);
        step(8'h00);
        step(8'h20);
        step(8'h00);
        // Random traffic at two request densities
        for (int n = 0; n < 3000; n++) begin
            if ((n / 500) % 2 == 0) step(W'($urandom) | W'($urandom));
            else                    step(W'($urandom) & W'($urandom));
        end
        check_eq("starvation_bound", 32'(max_wait <= BOUND), 32'd1);
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
